cceip_rbus_cmd_sequencer: RTL

Upstream feeder for the AXI-lite-to-APB bridge on the CCEIP register bus. It replaces the fixed single-write start/done driver with a command-stream sequencer. Each command is a write, a read, a masked poll, or an end marker; the block converts it into AXI-lite master transactions toward axi_apb_bridge_0. It reports the sequence result (done pulse plus error code) to the kernel control logic.

---
 rtl/cceip_rbus_pkg.sv | 32 +++
 rtl/cceip_rbus_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cceip_rbus_pkg.sv
// Shared types for the CCEIP register-bus command sequencer: command opcodes,
// sequence error codes, AXI response encoding and the sequencer FSM states.
package cceip_rbus_pkg;

    typedef enum logic [1:0] {
        RBUS_WRITE = 2'd0,
        RBUS_READ  = 2'd1,
        RBUS_POLL  = 2'd2,
        RBUS_END   = 2'd3
    } rbus_op_e;

    typedef enum logic [1:0] {
        RBUS_ERR_NONE    = 2'd0,
        RBUS_ERR_RESP    = 2'd1,
        RBUS_ERR_POLL    = 2'd2,
        RBUS_ERR_TIMEOUT = 2'd3
    } rbus_err_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WR       = 3'd2,
        ST_WR_RESP  = 3'd3,
        ST_RD_ADDR  = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_POLL_CHK = 3'd6,
        ST_DONE     = 3'd7
    } rbus_state_e;

endpackage

// File: rtl/cceip_rbus_cmd_sequencer.sv
// Command-stream sequencer driving AXI-lite master transactions toward the
// AXI-to-APB bridge; one transaction in flight at a time.
module cceip_rbus_cmd_sequencer
    import cceip_rbus_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int POLL_MAX    = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              seq_start,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [1:0]        seq_err,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int ATT_W = $clog2(POLL_MAX) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    rbus_state_e       state_q;
    rbus_op_e          op_q;
    rbus_err_e         err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] poll_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ATT_W-1:0]  attempt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              busy_q;
    logic              done_q;
    logic              cmd_ready_q;
    logic              rd_valid_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;

    logic              tmo_hit_s;
    logic              wr_both_s;
    logic              poll_match_s;

    assign tmo_hit_s    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    // A channel counts as finished once its valid has already dropped or it handshakes now.
    assign wr_both_s    = (!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready);
    assign poll_match_s = (((poll_q ^ data_q) & mask_q) == '0);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            op_q        <= RBUS_WRITE;
            err_q       <= RBUS_ERR_NONE;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            poll_q      <= '0;
            rd_data_q   <= '0;
            attempt_q   <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (seq_start) begin
                        state_q     <= ST_FETCH;
                        busy_q      <= 1'b1;
                        err_q       <= RBUS_ERR_NONE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= rbus_op_e'(cmd_op);
                        addr_q      <= cmd_addr;
                        data_q      <= cmd_data;
                        mask_q      <= cmd_mask;
                        attempt_q   <= '0;
                        tmo_q       <= '0;
                        case (rbus_op_e'(cmd_op))
                            RBUS_WRITE: begin
                                state_q   <= ST_WR;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                            end
                            RBUS_READ, RBUS_POLL: begin
                                state_q   <= ST_RD_ADDR;
                                arvalid_q <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                err_q   <= RBUS_ERR_NONE;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if (wr_both_s) begin
                        state_q  <= ST_WR_RESP;
                        bready_q <= 1'b1;
                        tmo_q    <= '0;
                    end else if (tmo_hit_s) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        err_q     <= RBUS_ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp == AXI_RESP_OKAY) begin
                            state_q     <= ST_FETCH;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= RBUS_ERR_RESP;
                        end
                    end else if (tmo_hit_s) begin
                        bready_q <= 1'b0;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        err_q    <= RBUS_ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= ST_RD_DATA;
                    end else if (tmo_hit_s) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        err_q     <= RBUS_ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axi_rresp != AXI_RESP_OKAY) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= RBUS_ERR_RESP;
                        end else if (op_q == RBUS_READ) begin
                            rd_data_q   <= m_axi_rdata;
                            rd_valid_q  <= 1'b1;
                            state_q     <= ST_FETCH;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            poll_q  <= m_axi_rdata;
                            state_q <= ST_POLL_CHK;
                        end
                    end else if (tmo_hit_s) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        err_q    <= RBUS_ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_POLL_CHK: begin
                    if (poll_match_s) begin
                        state_q     <= ST_FETCH;
                        cmd_ready_q <= 1'b1;
                    end else if (attempt_q == ATT_W'(POLL_MAX - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= RBUS_ERR_POLL;
                    end else begin
                        attempt_q <= attempt_q + ATT_W'(1);
                        arvalid_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= ST_RD_ADDR;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign seq_err       = err_q;
    assign cmd_ready     = cmd_ready_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
